rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
- Shares the single-port 128x8 program ROM between two requesters.
- Port 0 is the CPU instruction-fetch unit. Port 1 is the debug/loader read port.
- Owns the ROM address bus, captures the ROM's combinational read data into a per-port register, and returns it with a one-cycle ack pulse.
- Selects between fixed priority with anti-starvation, or round-robin, set by parameter.

Parameters:
- ADDR_W, 7: ROM address width (128 locations).
- DATA_W, 8: ROM data width.
- FIXED_PRI, 1: 1 = port 0 wins contested arbitration, subject to MAX_WAIT. 0 = round-robin.
- MAX_WAIT, 4: with FIXED_PRI=1, the number of consecutive port 0 grants made while req1 is pending, after which port 1 must win the next arbitration. Range 1..15.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high with addr0 stable until ack0.
- addr0  in  ADDR_W  port 0 read address.
- ack0  out  1  one-cycle pulse; rdata0 valid in the same cycle.
- rdata0  out  DATA_W  port 0 read data; holds its value until the next ack0.
- req1  in  1  port 1 request (same rules as req0).
- addr1  in  ADDR_W  port 1 read address.
- ack1  out  1  port 1 ack pulse.
- rdata1  out  DATA_W  port 1 read data register.
- rom_addr  out  ADDR_W  registered address driven to the ROM.
- rom_data  in  DATA_W  combinational ROM read data.
- busy  out  1  high while the FSM is in READ or ACK.
- grant_id  out  1  port owning the current or last access.

Behaviour:
- Reset values, applied at a clock edge with reset=1: state=IDLE; rom_addr=0; rdata0=rdata1=0; ack0=ack1=0; busy=0; grant_id=0; wait_cnt=0; rr_last=1 (so port 0 wins the first round-robin tie).
- FSM has three states: IDLE, READ, ACK.
  - IDLE, no request: stay in IDLE.
  - IDLE, any reqN: select a winner W; register rom_addr<=addrW and grant_id<=W; go to READ.
  - READ: rom_data settles from the registered rom_addr. At the end of the cycle, rdataW<=rom_data, ackW<=1, go to ACK.
  - ACK: ackW is high for exactly this cycle; go to IDLE unconditionally. Requests are not sampled in ACK.
- Latency: req sampled in IDLE at cycle t -> ack at cycle t+2. One access completes every 3 cycles per port.
- Requester rules:
  - Deassert reqN in the cycle after ackN.
  - Or keep it high with a new addrN for a back-to-back access. That request is sampled in the following IDLE cycle.
  - Changing addrN while reqN is high and before ackN is a protocol error. The arbiter uses whatever value is on addrN at grant.
- Selection with FIXED_PRI=1:
  - Both requesting, wait_cnt<MAX_WAIT: W=0 and wait_cnt increments.
  - Both requesting, wait_cnt==MAX_WAIT: W=1.
  - Any port 1 grant clears wait_cnt.
  - An uncontested port 0 grant leaves wait_cnt unchanged.
- Selection with FIXED_PRI=0: if both request, W = !rr_last. A single requester always wins. rr_last<=W on every grant.
- Only the winning port's rdata register is written. The other port's rdata holds.
- Address wrap: addresses are ADDR_W bits, so 0x7F is the last location. No wrap logic is needed and no out-of-range case exists.
- Reset mid-operation (in READ or ACK): go to IDLE at that edge. No ack is issued for the in-flight access, and a pending ack is cleared. Requesters must re-request after reset.
- ack0 and ack1 are never high in the same cycle.
- ackN is never asserted without a prior grant to N.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, READ=2'd1, ACK=2'd2;
  - port ID constants: PORT_CPU=1'b0, PORT_DBG=1'b1;
  - the ROM ADDR_W and DATA_W constants shared with the ROM.
- One sub-module, rom_arb_select: combinational winner pick from req0, req1, wait_cnt, rr_last and FIXED_PRI. It is unit-testable on its own.

Test Plan:
All scenarios use the ROM's default program contents: ROM[0..5] = 86, AA, 96, F0, 20, FE.
1. After reset, req0=1 with addr0=0x01 at cycle t -> rom_addr=0x01 in t+1; ack0=1 and rdata0=0xAA in t+2; ack1 stays 0 and rdata1 stays 0x00.
2. FIXED_PRI=1; req0 (addr 0x02) and req1 (addr 0x03) both raised at t; req0 dropped after its ack -> ack0 with 0x96 at t+2, ack1 with 0xF0 at t+5, grant_id=1 from t+4.
3. FIXED_PRI=1, MAX_WAIT=4; req0 held back-to-back on addr 0x00 while req1 is held on addr 0x05 -> four ack0 (0x86 each), then ack1 with rdata1=0xFE, then port 0 resumes with wait_cnt=0.
4. FIXED_PRI=0; both ports held back-to-back (addr0=0x04, addr1=0x02) -> acks alternate 0,1,0,1 with rdata0=0x20 and rdata1=0x96, starting with port 0.
5. Reset asserted during READ of a port 1 request -> no ack1 at any point; busy=0, rom_addr=0x00 and state=IDLE in the cycle after reset; the next req1 completes normally.
6. req1 with addr1=0x7F -> ack1 with rdata1=0x00 (unprogrammed location); rdata0 is unchanged from its previous value.

Source files
------------

// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants for the program-ROM fetch arbiter: ROM geometry,
// FSM state encoding and requester port IDs.
package rom_fetch_arbiter_pkg;

  localparam int unsigned ROM_ADDR_W = 7;
  localparam int unsigned ROM_DATA_W = 8;
  localparam int unsigned WAIT_W     = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rom_arb_select.sv
// Combinational winner pick between the CPU fetch port and the debug port.
module rom_arb_select
  import rom_fetch_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRI = 1'b1,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [WAIT_W-1:0] i_wait_cnt,
  input  logic              i_rr_last,
  output logic              o_any_c,
  output logic              o_winner_c
);

  // Contested: fixed priority yields to port 1 once the wait budget is spent
  always_comb begin
    o_any_c    = i_req0 | i_req1;
    o_winner_c = PORT_CPU;
    if (i_req0 && i_req1) begin
      if (FIXED_PRI) begin
        o_winner_c = (i_wait_cnt >= WAIT_W'(MAX_WAIT)) ? PORT_DBG : PORT_CPU;
      end else begin
        o_winner_c = ~i_rr_last;
      end
    end else if (i_req1) begin
      o_winner_c = PORT_DBG;
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter for the single-port program ROM: registers the address,
// captures the ROM read data into the winner's register and pulses its ack.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ROM_ADDR_W,
  parameter int unsigned DATA_W    = ROM_DATA_W,
  parameter bit          FIXED_PRI = 1'b1,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              grant_id
);

  logic [1:0]        r_state,    w_state_nxt;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_nxt;
  logic [DATA_W-1:0] r_rdata0,   w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1,   w_rdata1_nxt;
  logic              r_ack0,     w_ack0_nxt;
  logic              r_ack1,     w_ack1_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_grant,    w_grant_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_rr_last,  w_rr_last_nxt;
  logic              w_any;
  logic              w_winner;

  rom_arb_select #(
    .FIXED_PRI (FIXED_PRI),
    .MAX_WAIT  (MAX_WAIT)
  ) u_select (
    .i_req0     (req0),
    .i_req1     (req1),
    .i_wait_cnt (r_wait_cnt),
    .i_rr_last  (r_rr_last),
    .o_any_c    (w_any),
    .o_winner_c (w_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rom_addr <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= PORT_CPU;
      r_wait_cnt <= '0;
      r_rr_last  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_rdata0   <= w_rdata0_nxt;
      r_rdata1   <= w_rdata1_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_busy     <= w_busy_nxt;
      r_grant    <= w_grant_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_rr_last  <= w_rr_last_nxt;
    end
  end

  // Next-state and next-output logic; acks default low so they pulse once
  always_comb begin
    w_state_nxt    = r_state;
    w_rom_addr_nxt = r_rom_addr;
    w_rdata0_nxt   = r_rdata0;
    w_rdata1_nxt   = r_rdata1;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    w_grant_nxt    = r_grant;
    w_wait_cnt_nxt = r_wait_cnt;
    w_rr_last_nxt  = r_rr_last;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt    = READ;
          w_busy_nxt     = 1'b1;
          w_grant_nxt    = w_winner;
          w_rr_last_nxt  = w_winner;
          w_rom_addr_nxt = (w_winner == PORT_DBG) ? addr1 : addr0;
          if (w_winner == PORT_DBG) begin
            w_wait_cnt_nxt = '0;
          end else if (req1) begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      READ: begin
        w_state_nxt = ACK;
        if (r_grant == PORT_DBG) begin
          w_rdata1_nxt = rom_data;
          w_ack1_nxt   = 1'b1;
        end else begin
          w_rdata0_nxt = rom_data;
          w_ack0_nxt   = 1'b1;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign rom_addr = r_rom_addr;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: a fixed-priority instance (index 0) and a
// round-robin instance (index 1), each checked every cycle against a model.
module tb_rom_fetch_arbiter;

  logic       clk;
  logic       reset;
  logic       t_req0  [2];
  logic       t_req1  [2];
  logic [6:0] t_addr0 [2];
  logic [6:0] t_addr1 [2];
  logic       d_ack0  [2];
  logic       d_ack1  [2];
  logic [7:0] d_rd0   [2];
  logic [7:0] d_rd1   [2];
  logic [6:0] d_raddr [2];
  logic [7:0] d_rdata [2];
  logic       d_busy  [2];
  logic       d_gid   [2];
  logic [7:0] rom_mem [128];

  int n_chk = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign d_rdata[0] = rom_mem[d_raddr[0]];
  assign d_rdata[1] = rom_mem[d_raddr[1]];

  rom_fetch_arbiter #(.ADDR_W(7), .DATA_W(8), .FIXED_PRI(1'b1), .MAX_WAIT(4)) u_fix (
    .clk(clk), .reset(reset),
    .req0(t_req0[0]), .addr0(t_addr0[0]), .ack0(d_ack0[0]), .rdata0(d_rd0[0]),
    .req1(t_req1[0]), .addr1(t_addr1[0]), .ack1(d_ack1[0]), .rdata1(d_rd1[0]),
    .rom_addr(d_raddr[0]), .rom_data(d_rdata[0]), .busy(d_busy[0]), .grant_id(d_gid[0])
  );

  rom_fetch_arbiter #(.ADDR_W(7), .DATA_W(8), .FIXED_PRI(1'b0), .MAX_WAIT(4)) u_rr (
    .clk(clk), .reset(reset),
    .req0(t_req0[1]), .addr0(t_addr0[1]), .ack0(d_ack0[1]), .rdata0(d_rd0[1]),
    .req1(t_req1[1]), .addr1(t_addr1[1]), .ack1(d_ack1[1]), .rdata1(d_rd1[1]),
    .rom_addr(d_raddr[1]), .rom_data(d_rdata[1]), .busy(d_busy[1]), .grant_id(d_gid[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access occupies a 3-cycle slot; the ack and
  // captured data appear two edges after the grant.
  bit         m_valid = 1'b0;
  int         m_left  [2];
  logic       m_win   [2];
  logic [6:0] m_addr  [2];
  logic [7:0] m_rd0   [2];
  logic [7:0] m_rd1   [2];
  logic       m_ack0  [2];
  logic       m_ack1  [2];
  logic       m_busy  [2];
  int         m_wait  [2];
  logic       m_rr    [2];

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          m_valid = 1'b1;
          m_left[k] = 0; m_win[k] = 1'b0; m_addr[k] = '0;
          m_rd0[k] = '0; m_rd1[k] = '0; m_ack0[k] = 1'b0; m_ack1[k] = 1'b0;
          m_busy[k] = 1'b0; m_wait[k] = 0; m_rr[k] = 1'b1;
        end else begin
          m_ack0[k] = 1'b0;
          m_ack1[k] = 1'b0;
          if (m_left[k] == 2) begin
            if (m_win[k]) begin m_rd1[k] = rom_mem[m_addr[k]]; m_ack1[k] = 1'b1; end
            else          begin m_rd0[k] = rom_mem[m_addr[k]]; m_ack0[k] = 1'b1; end
            m_left[k] = 1;
          end else if (m_left[k] == 1) begin
            m_busy[k] = 1'b0;
            m_left[k] = 0;
          end else if (t_req0[k] || t_req1[k]) begin
            if (t_req0[k] && t_req1[k])
              m_win[k] = (k == 0) ? (m_wait[k] == 4) : !m_rr[k];
            else
              m_win[k] = t_req1[k];
            if (k == 0) begin
              if (m_win[k]) m_wait[k] = 0;
              else if (t_req1[k]) m_wait[k] = m_wait[k] + 1;
            end
            m_rr[k]   = m_win[k];
            m_addr[k] = m_win[k] ? t_addr1[k] : t_addr0[k];
            m_busy[k] = 1'b1;
            m_left[k] = 2;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("i%0d_ack0", k), 32'(d_ack0[k]), 32'(m_ack0[k]));
          chk($sformatf("i%0d_ack1", k), 32'(d_ack1[k]), 32'(m_ack1[k]));
          chk($sformatf("i%0d_rdata0", k), 32'(d_rd0[k]), 32'(m_rd0[k]));
          chk($sformatf("i%0d_rdata1", k), 32'(d_rd1[k]), 32'(m_rd1[k]));
          chk($sformatf("i%0d_rom_addr", k), 32'(d_raddr[k]), 32'(m_addr[k]));
          chk($sformatf("i%0d_busy", k), 32'(d_busy[k]), 32'(m_busy[k]));
          chk($sformatf("i%0d_grant_id", k), 32'(d_gid[k]), 32'(m_win[k]));
          chk($sformatf("i%0d_ack_excl", k), 32'(d_ack0[k] & d_ack1[k]), 32'd0);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'h00;
    rom_mem[0] = 8'h86; rom_mem[1] = 8'hAA; rom_mem[2] = 8'h96;
    rom_mem[3] = 8'hF0; rom_mem[4] = 8'h20; rom_mem[5] = 8'hFE;
    for (int k = 0; k < 2; k++) begin
      t_req0[k] = 1'b0; t_req1[k] = 1'b0; t_addr0[k] = '0; t_addr1[k] = '0;
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ack0", 32'(d_ack0[0]), 32'd0);
    chk("rst_rdata0", 32'(d_rd0[0]), 32'd0);
    chk("rst_rom_addr", 32'(d_raddr[0]), 32'd0);
    chk("rst_busy", 32'(d_busy[0]), 32'd0);
    chk("rst_grant_id", 32'(d_gid[0]), 32'd0);
    chk("rst_state", 32'(u_fix.r_state), 32'd0);

    // 1: single port 0 read of 0x01
    t_req0[0] = 1'b1; t_addr0[0] = 7'h01;
    tick();
    chk("t1_rom_addr", 32'(d_raddr[0]), 32'h01);
    chk("t1_busy", 32'(d_busy[0]), 32'd1);
    tick();
    chk("t1_ack0", 32'(d_ack0[0]), 32'd1);
    chk("t1_rdata0", 32'(d_rd0[0]), 32'hAA);
    chk("t1_ack1", 32'(d_ack1[0]), 32'd0);
    chk("t1_rdata1", 32'(d_rd1[0]), 32'h00);
    t_req0[0] = 1'b0;
    tick(); tick();

    // 2: contested request, port 0 first, port 1 follows
    t_req0[0] = 1'b1; t_addr0[0] = 7'h02;
    t_req1[0] = 1'b1; t_addr1[0] = 7'h03;
    tick();
    chk("t2_grant0", 32'(d_gid[0]), 32'd0);
    tick();
    chk("t2_ack0", 32'(d_ack0[0]), 32'd1);
    chk("t2_rdata0", 32'(d_rd0[0]), 32'h96);
    t_req0[0] = 1'b0;
    tick(); tick();
    chk("t2_grant1", 32'(d_gid[0]), 32'd1);
    chk("t2_rom_addr", 32'(d_raddr[0]), 32'h03);
    tick();
    chk("t2_ack1", 32'(d_ack1[0]), 32'd1);
    chk("t2_rdata1", 32'(d_rd1[0]), 32'hF0);
    t_req1[0] = 1'b0;
    tick(); tick();

    // 3: anti-starvation after four contested port 0 grants
    t_req0[0] = 1'b1; t_addr0[0] = 7'h00;
    t_req1[0] = 1'b1; t_addr1[0] = 7'h05;
    for (int n = 0; n < 4; n++) begin
      tick(); tick();
      chk($sformatf("t3_ack0_%0d", n), 32'(d_ack0[0]), 32'd1);
      chk($sformatf("t3_rdata0_%0d", n), 32'(d_rd0[0]), 32'h86);
      chk($sformatf("t3_noack1_%0d", n), 32'(d_ack1[0]), 32'd0);
      tick();
    end
    tick(); tick();
    chk("t3_ack1", 32'(d_ack1[0]), 32'd1);
    chk("t3_rdata1", 32'(d_rd1[0]), 32'hFE);
    t_req1[0] = 1'b0;
    tick();
    chk("t3_wait_cleared", 32'(u_fix.r_wait_cnt), 32'd0);
    tick(); tick();
    chk("t3_resume_ack0", 32'(d_ack0[0]), 32'd1);
    t_req0[0] = 1'b0;
    tick(); tick();

    // 4: round-robin alternation on the second instance
    t_req0[1] = 1'b1; t_addr0[1] = 7'h04;
    t_req1[1] = 1'b1; t_addr1[1] = 7'h02;
    for (int n = 0; n < 4; n++) begin
      tick(); tick();
      chk($sformatf("t4_ack0_%0d", n), 32'(d_ack0[1]), 32'((n % 2) == 0));
      chk($sformatf("t4_ack1_%0d", n), 32'(d_ack1[1]), 32'((n % 2) == 1));
      if (n == 3) begin
        chk("t4_rdata0", 32'(d_rd0[1]), 32'h20);
        chk("t4_rdata1", 32'(d_rd1[1]), 32'h96);
        t_req0[1] = 1'b0; t_req1[1] = 1'b0;
      end
      tick();
    end
    tick();

    // 5: reset during READ of a port 1 access
    t_req1[0] = 1'b1; t_addr1[0] = 7'h03;
    tick();
    chk("t5_in_read", 32'(u_fix.r_state), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_no_ack1", 32'(d_ack1[0]), 32'd0);
    chk("t5_busy", 32'(d_busy[0]), 32'd0);
    chk("t5_rom_addr", 32'(d_raddr[0]), 32'd0);
    chk("t5_state", 32'(u_fix.r_state), 32'd0);
    tick();
    chk("t5_no_ack1_b", 32'(d_ack1[0]), 32'd0);
    tick();
    chk("t5_ack1", 32'(d_ack1[0]), 32'd1);
    chk("t5_rdata1", 32'(d_rd1[0]), 32'hF0);
    t_req1[0] = 1'b0;
    tick(); tick();

    // 6: last ROM location, other port's data holds
    t_req0[0] = 1'b1; t_addr0[0] = 7'h05;
    tick(); tick();
    chk("t6_rdata0", 32'(d_rd0[0]), 32'hFE);
    t_req0[0] = 1'b0;
    tick();
    t_req1[0] = 1'b1; t_addr1[0] = 7'h7F;
    tick();
    chk("t6_rom_addr", 32'(d_raddr[0]), 32'h7F);
    tick();
    chk("t6_ack1", 32'(d_ack1[0]), 32'd1);
    chk("t6_rdata1", 32'(d_rd1[0]), 32'h00);
    chk("t6_rdata0_hold", 32'(d_rd0[0]), 32'hFE);
    t_req1[0] = 1'b0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
